// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single req/ready slave.
// Each access is latched on grant, run against the slave (or rejected on a
// decode miss) and answered with a one-cycle registered ack to the winner.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's access
// BUSY  | slave strobe asserted; waiting for s_ready or the timeout
// RESP  | one-cycle ack/err/rdata to the granted master

module bus_arbiter #(
  parameter int unsigned   TIMEOUT = 16,
  parameter logic [31:0]   ADDR_LO = 32'h0000_0000,
  parameter logic [31:0]   ADDR_HI = 32'h0000_7FFF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,

  output logic        s_req,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_we,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,

  output logic        grant,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          grant_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    we_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          any_req;
  logic          winner;
  logic [31:0]   sel_addr;
  logic [32:0]   lo_diff;
  logic [32:0]   hi_diff;
  logic          in_range;
  logic          timed_out;

  // Arbitration and address decode for the candidate winner in IDLE.
  // The range check uses borrow bits so it stays clean for any ADDR_LO/HI.
  always_comb begin
    any_req  = m0_req | m1_req;
    winner   = (m0_req && m1_req) ? ~last_grant : m1_req;
    sel_addr = winner ? m1_addr : m0_addr;
    lo_diff  = {1'b0, sel_addr} - {1'b0, ADDR_LO};
    hi_diff  = {1'b0, ADDR_HI} - {1'b0, sel_addr};
    in_range = ~lo_diff[32] & ~hi_diff[32];
    timed_out = (cnt == CNT_LAST) && !s_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = in_range ? BUSY : RESP;
      BUSY: if (s_ready || timed_out) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access latches, grant tracking, timeout counter and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            grant_q    <= winner;
            last_grant <= winner;
            addr_q     <= sel_addr;
            wdata_q    <= winner ? m1_wdata : m0_wdata;
            we_q       <= winner ? m1_we : m0_we;
            rdata_q    <= '0;
            err_q      <= ~in_range;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (s_ready) begin
            rdata_q <= (we_q != 4'b0000) ? 32'h0 : s_rdata;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RESP: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs are decoded from state and registers only.
  always_comb begin
    s_req    = (state == BUSY);
    busy     = (state != IDLE);
    grant    = grant_q;
    s_addr   = addr_q;
    s_wdata  = wdata_q;
    s_we     = we_q;
    m0_ack   = (state == RESP) && !grant_q;
    m1_ack   = (state == RESP) &&  grant_q;
    m0_err   = m0_ack & err_q;
    m1_err   = m1_ack & err_q;
    m0_rdata = m0_ack ? rdata_q : 32'h0;
    m1_rdata = m1_ack ? rdata_q : 32'h0;
  end

endmodule
